// File: rtl/fsm_onehot.sv
`default_nettype none
// ============================================================================
// Module      : fsm_onehot
// Description : Ten-state one-hot Moore decoder (combinational) plus a
//               registered state holder that reuses the same decoder.
// Revision    : 1.0  initial release
// ============================================================================
module fsm_onehot (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    input  logic [9:0] state,
    output logic [9:0] next_state,
    output logic       out1,
    output logic       out2,
    output logic [9:0] cur_state,
    output logic       cur_out1,
    output logic       cur_out2
);

    localparam logic [9:0] c_S0 = 10'h001;

    // Bitwise sum-of-products: a non-one-hot vector yields the OR of the
    // contributions of every set bit, which downstream checkers rely on.
    function automatic logic [9:0] f_next(input logic [9:0] s, input logic b);
        logic [9:0] n;
        n[0] = ~b & (s[0] | s[1] | s[2] | s[3] | s[4] | s[7] | s[8] | s[9]);
        n[1] =  b & (s[0] | s[8] | s[9]);
        n[2] =  b & s[1];
        n[3] =  b & s[2];
        n[4] =  b & s[3];
        n[5] =  b & s[4];
        n[6] =  b & s[5];
        n[7] =  b & (s[6] | s[7]);
        n[8] = ~b & s[5];
        n[9] = ~b & s[6];
        return n;
    endfunction

    logic [9:0] r_state;
    logic [9:0] w_cur_next;

    always_comb begin
        next_state = f_next(state, in);
        out1       = state[8] | state[9];
        out2       = state[7] | state[9];
    end

    always_comb begin
        w_cur_next = f_next(r_state, in);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S0;
        end else begin
            r_state <= w_cur_next;
        end
    end

    always_comb begin
        cur_state = r_state;
        cur_out1  = r_state[8] | r_state[9];
        cur_out2  = r_state[7] | r_state[9];
    end

endmodule
`default_nettype wire

// File: tb/tb_fsm_onehot.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_onehot
// Description : Table-driven check of the combinational decoder plus directed
//               sequences for the registered state holder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fsm_onehot;

    logic       clk;
    logic       reset;
    logic       in;
    logic [9:0] state;
    logic [9:0] next_state;
    logic       out1;
    logic       out2;
    logic [9:0] cur_state;
    logic       cur_out1;
    logic       cur_out2;

    int checks = 0;
    int errors = 0;

    fsm_onehot dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .state      (state),
        .next_state (next_state),
        .out1       (out1),
        .out2       (out2),
        .cur_state  (cur_state),
        .cur_out1   (cur_out1),
        .cur_out2   (cur_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] st;
        logic       b;
        logic [9:0] ns;
        logic       o1;
        logic       o2;
    } vec_t;

    vec_t vecs[26];

    task automatic check_reg(input string name, input logic [9:0] es,
                             input logic eo1, input logic eo2);
        checks++;
        if (cur_state !== es || cur_out1 !== eo1 || cur_out2 !== eo2) begin
            errors++;
            $display("FAIL %s: got state=%h o1=%b o2=%b, expected state=%h o1=%b o2=%b",
                     name, cur_state, cur_out1, cur_out2, es, eo1, eo2);
        end
    endtask

    // Apply one input bit, clock it in, then sample 1 time unit after the edge.
    task automatic step(input string name, input logic b, input logic [9:0] es,
                        input logic eo1, input logic eo2);
        in = b;
        @(posedge clk);
        #1;
        check_reg(name, es, eo1, eo2);
    endtask

    initial begin
        // One-hot sweep, in=0 then in=1
        vecs[0]  = '{10'h001, 1'b0, 10'h001, 1'b0, 1'b0};
        vecs[1]  = '{10'h002, 1'b0, 10'h001, 1'b0, 1'b0};
        vecs[2]  = '{10'h004, 1'b0, 10'h001, 1'b0, 1'b0};
        vecs[3]  = '{10'h008, 1'b0, 10'h001, 1'b0, 1'b0};
        vecs[4]  = '{10'h010, 1'b0, 10'h001, 1'b0, 1'b0};
        vecs[5]  = '{10'h020, 1'b0, 10'h100, 1'b0, 1'b0};
        vecs[6]  = '{10'h040, 1'b0, 10'h200, 1'b0, 1'b0};
        vecs[7]  = '{10'h080, 1'b0, 10'h001, 1'b0, 1'b1};
        vecs[8]  = '{10'h100, 1'b0, 10'h001, 1'b1, 1'b0};
        vecs[9]  = '{10'h200, 1'b0, 10'h001, 1'b1, 1'b1};
        vecs[10] = '{10'h001, 1'b1, 10'h002, 1'b0, 1'b0};
        vecs[11] = '{10'h002, 1'b1, 10'h004, 1'b0, 1'b0};
        vecs[12] = '{10'h004, 1'b1, 10'h008, 1'b0, 1'b0};
        vecs[13] = '{10'h008, 1'b1, 10'h010, 1'b0, 1'b0};
        vecs[14] = '{10'h010, 1'b1, 10'h020, 1'b0, 1'b0};
        vecs[15] = '{10'h020, 1'b1, 10'h040, 1'b0, 1'b0};
        vecs[16] = '{10'h040, 1'b1, 10'h080, 1'b0, 1'b0};
        vecs[17] = '{10'h080, 1'b1, 10'h080, 1'b0, 1'b1};
        vecs[18] = '{10'h100, 1'b1, 10'h002, 1'b1, 1'b0};
        vecs[19] = '{10'h200, 1'b1, 10'h002, 1'b1, 1'b1};
        // Multi-hot and degenerate vectors
        vecs[20] = '{10'h021, 1'b0, 10'h101, 1'b0, 1'b0};
        vecs[21] = '{10'h180, 1'b1, 10'h082, 1'b1, 1'b1};
        vecs[22] = '{10'h3FF, 1'b1, 10'h0FE, 1'b1, 1'b1};
        vecs[23] = '{10'h3FF, 1'b0, 10'h301, 1'b1, 1'b1};
        vecs[24] = '{10'h000, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[25] = '{10'h000, 1'b1, 10'h000, 1'b0, 1'b0};

        reset = 1'b1;
        in    = 1'b0;
        state = 10'h000;

        for (int i = 0; i < 26; i++) begin
            state = vecs[i].st;
            in    = vecs[i].b;
            #1;
            checks++;
            if (next_state !== vecs[i].ns || out1 !== vecs[i].o1 || out2 !== vecs[i].o2) begin
                errors++;
                $display("FAIL comb[%0d] st=%h in=%b: got ns=%h o1=%b o2=%b, expected ns=%h o1=%b o2=%b",
                         i, vecs[i].st, vecs[i].b, next_state, out1, out2,
                         vecs[i].ns, vecs[i].o1, vecs[i].o2);
            end
        end

        // Registered path; the state port is held at a junk value throughout.
        state = 10'h3FF;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("reset_in1", 1'b1, 10'h001, 1'b0, 1'b0);
        reset = 1'b0;
        step("seq_s1", 1'b1, 10'h002, 1'b0, 1'b0);
        step("seq_s2", 1'b1, 10'h004, 1'b0, 1'b0);
        step("seq_s3", 1'b1, 10'h008, 1'b0, 1'b0);
        step("seq_s4", 1'b1, 10'h010, 1'b0, 1'b0);
        step("seq_s5", 1'b1, 10'h020, 1'b0, 1'b0);
        step("seq_s8", 1'b0, 10'h100, 1'b1, 1'b0);
        step("s8_to_s1", 1'b1, 10'h002, 1'b0, 1'b0);
        step("a_s2", 1'b1, 10'h004, 1'b0, 1'b0);
        step("a_s3", 1'b1, 10'h008, 1'b0, 1'b0);
        step("a_s4", 1'b1, 10'h010, 1'b0, 1'b0);
        step("a_s5", 1'b1, 10'h020, 1'b0, 1'b0);
        step("a_s6", 1'b1, 10'h040, 1'b0, 1'b0);
        step("s6_to_s9", 1'b0, 10'h200, 1'b1, 1'b1);
        step("s9_to_s1", 1'b1, 10'h002, 1'b0, 1'b0);
        step("b_s2", 1'b1, 10'h004, 1'b0, 1'b0);
        step("b_s3", 1'b1, 10'h008, 1'b0, 1'b0);
        step("b_s4", 1'b1, 10'h010, 1'b0, 1'b0);
        step("b_s5", 1'b1, 10'h020, 1'b0, 1'b0);
        step("b_s6", 1'b1, 10'h040, 1'b0, 1'b0);
        step("s6_to_s7", 1'b1, 10'h080, 1'b0, 1'b1);
        step("s7_hold", 1'b1, 10'h080, 1'b0, 1'b1);

        // Reset raised between edges must not act until the next edge.
        reset = 1'b1;
        #3;
        check_reg("sync_reset_between_edges", 10'h080, 1'b0, 1'b1);
        step("reset_from_s7", 1'b1, 10'h001, 1'b0, 1'b0);
        reset = 1'b0;
        step("after_reset_s1", 1'b1, 10'h002, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsm_onehot.md
# fsm_onehot

Ten-state one-hot Moore machine block: a purely combinational next-state/output decoder plus a registered state holder built on the same decoder. The decoder derives each next-state bit and both outputs by inspection. It must give the exact equations below for any 10-bit state vector, including vectors that are not one-hot. The block sits in the control path of a serial bit-pattern detector.

## Interface
- No parameters.
- clk  input  1  rising-edge clock; used only by the registered state holder.
- reset  input  1  synchronous, active-high; forces the registered state to S0.
- in  input  1  serial input bit.
- state  input  10  externally supplied state vector for the combinational decoder; bit i = state Si.
- next_state  output  10  combinational next state computed from state and in.
- out1  output  1  combinational Moore output from state.
- out2  output  1  combinational Moore output from state.
- cur_state  output  10  registered state, same encoding.
- cur_out1  output  1  out1 decoded from cur_state, combinational from the register.
- cur_out2  output  1  out2 decoded from cur_state, combinational from the register.

## Operation
- State encoding: one-hot, S0..S9 = bits 0..9.
- Transitions, written as state: in=0 -> next / in=1 -> next:
  - S0..S4: in=0 -> S0; in=1 -> S(i+1).
  - S5: in=0 -> S8; in=1 -> S6.
  - S6: in=0 -> S9; in=1 -> S7.
  - S7: in=0 -> S0; in=1 -> S7.
  - S8: in=0 -> S0; in=1 -> S1.
  - S9: in=0 -> S0; in=1 -> S1.
- Output decode (Moore):
  - out1 = state[8] | state[9].
  - out2 = state[7] | state[9].
- Next-state equations. These are mandatory bitwise sum-of-products, with no one-hot assumption, no priority and no case-on-whole-vector:
  - ns[0] = !in & (state[0]|state[1]|state[2]|state[3]|state[4]|state[7]|state[8]|state[9])
  - ns[1] = in & (state[0]|state[8]|state[9])
  - ns[2] = in & state[1]; ns[3] = in & state[2]; ns[4] = in & state[3]
  - ns[5] = in & state[4]; ns[6] = in & state[5]
  - ns[7] = in & (state[6]|state[7])
  - ns[8] = !in & state[5]; ns[9] = !in & state[6]
- Non-one-hot inputs: the result is the OR of the contributions of every set bit. state = 0 gives next_state = 0 and out1 = out2 = 0.
- Registered path:
  - cur_state loads the same equations applied to cur_state and in.
  - cur_out1/cur_out2 use the same output decode applied to cur_state.
  - The registered path is independent of the state input port.

## Timing
- next_state, out1, out2: zero latency, purely combinational from state/in. No clock dependency, no X on any output for 0/1 inputs.
- cur_state updates on the rising clk edge.
- reset = 1 at an edge gives cur_state = 10'h001, so cur_out1 = cur_out2 = 0. Reset overrides in.
- Reset asserted mid-sequence takes effect at the next edge.
- Reset is synchronous: asserting it between edges does not change cur_state.
- cur_out1/cur_out2 change only after cur_state changes, i.e. one cycle after the input that caused the transition.

## Test plan
- One-hot sweep: state = 1<<i for i = 0..9 with in=0, then with in=1 -> next_state per the transition list.
  - Example: state=10'h020, in=0 -> next_state=10'h100. Same state, in=1 -> 10'h040.
  - state=10'h200 -> out1=1, out2=1.
- Two-hot: state=10'h021 (S0|S5), in=0 -> next_state=10'h101, out1=0, out2=0. state=10'h180, in=1 -> next_state=10'h082, out1=1, out2=1.
- All-ones: state=10'h3FF, in=1 -> next_state=10'h0FE. Same state, in=0 -> next_state=10'h301. out1=out2=1 in both cases.
- Zero vector: state=10'h000 with in=0 and with in=1 -> next_state=10'h000, out1=0, out2=0.
- Registered sequence: reset for one edge -> cur_state=10'h001. Then in=1,1,1,1,1,0 on successive edges -> cur_state S1,S2,S3,S4,S5,S8, with cur_out1=1 and cur_out2=0 in S8. Then in=1 -> S1.
- Registered S9/S7 path: from S6, in=0 -> S9 (cur_out1=cur_out2=1). From S6, in=1 -> S7 (cur_out2=1); S7 holds under in=1. Reset asserted while in S7 -> 10'h001 at the next edge.
